// File: rtl/sap_1_microprogram_sequencer_if.sv
// Bus between the SAP-1 microprogram sequencer and the decode/control-ROM side.
// Optional step_mode/step debug signals exist only when SAP_1_SINGLE_STEP_EN is defined.
interface sap_1_microprogram_sequencer_if;
    logic        start;
    logic [15:0] op_onehot;
    logic [7:0]  map_addr;
    logic        mi_end;
    logic        hlt;
`ifdef SAP_1_SINGLE_STEP_EN
    logic        step_mode;
    logic        step;
`endif
    logic [7:0]  upc;
    logic [5:0]  t_state;
    logic        running;
    logic        halted;
    logic        illegal_op;

`ifdef SAP_1_SINGLE_STEP_EN
    modport master (
        input  start, op_onehot, map_addr, mi_end, hlt, step_mode, step,
        output upc, t_state, running, halted, illegal_op
    );
    modport slave (
        output start, op_onehot, map_addr, mi_end, hlt, step_mode, step,
        input  upc, t_state, running, halted, illegal_op
    );
`else
    modport master (
        input  start, op_onehot, map_addr, mi_end, hlt,
        output upc, t_state, running, halted, illegal_op
    );
    modport slave (
        output start, op_onehot, map_addr, mi_end, hlt,
        input  upc, t_state, running, halted, illegal_op
    );
`endif
endinterface

// File: rtl/sap_1_microprogram_sequencer.sv
// SAP-1 microprogram sequencer: fixed fetch T1..T3, mapped execute T4..T6, run/halt and illegal-opcode flag.
// Optional single-step gating is compiled in with SAP_1_SINGLE_STEP_EN.
module sap_1_microprogram_sequencer #(
    parameter logic [7:0] FETCH_BASE = 8'h00,
    parameter int         EXEC_STEPS = 3
) (
    input  logic clk,
    input  logic rst_n,
    sap_1_microprogram_sequencer_if.master bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam logic [5:0] T_NONE = 6'b000000;
    localparam logic [5:0] T_1    = 6'b000001;
    localparam logic [5:0] T_4    = 6'b001000;

    localparam logic [1:0] STEP_LAST = 2'(EXEC_STEPS);

    logic [1:0] state_q, state_d;
    logic [7:0] upc_q, upc_d;
    logic [5:0] t_state_q, t_state_d;
    logic [1:0] step_cnt_q, step_cnt_d;
    logic       illegal_q, illegal_d;

    logic       advance;
    logic       op_legal;

    // Exactly-one-hot check: seen_one marks any set bit so far, seen_two a second one.
    logic [16:0] seen_one;
    logic [16:0] seen_two;

    assign seen_one[0] = 1'b0;
    assign seen_two[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_onehot
            assign seen_one[gi+1] = seen_one[gi] | bus.op_onehot[gi];
            assign seen_two[gi+1] = seen_two[gi] | (seen_one[gi] & bus.op_onehot[gi]);
        end
    endgenerate

    assign op_legal = seen_one[16] & ~seen_two[16];

`ifdef SAP_1_SINGLE_STEP_EN
    assign advance = ~bus.step_mode | bus.step;
`else
    assign advance = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        upc_d      = upc_q;
        t_state_d  = t_state_q;
        step_cnt_d = step_cnt_q;
        illegal_d  = illegal_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d    = ST_FETCH;
                    upc_d      = FETCH_BASE;
                    t_state_d  = T_1;
                    step_cnt_d = 2'd0;
                end
            end

            ST_FETCH: begin
                if (advance) begin
                    if (t_state_q[2]) begin
                        // Priority at the end of T3: halt, then legality, then execute entry.
                        if (bus.hlt) begin
                            state_d   = ST_HALT;
                            t_state_d = T_NONE;
                        end else if (!op_legal) begin
                            illegal_d = 1'b1;
                            upc_d     = FETCH_BASE;
                            t_state_d = T_1;
                        end else begin
                            state_d    = ST_EXEC;
                            upc_d      = bus.map_addr;
                            t_state_d  = T_4;
                            step_cnt_d = 2'd1;
                        end
                    end else begin
                        upc_d     = upc_q + 8'd1;
                        t_state_d = {t_state_q[4:0], 1'b0};
                    end
                end
            end

            ST_EXEC: begin
                if (advance) begin
                    if (bus.mi_end || (step_cnt_q == STEP_LAST)) begin
                        state_d    = ST_FETCH;
                        upc_d      = FETCH_BASE;
                        t_state_d  = T_1;
                        step_cnt_d = 2'd0;
                    end else begin
                        upc_d      = upc_q + 8'd1;
                        t_state_d  = {t_state_q[4:0], 1'b0};
                        step_cnt_d = step_cnt_q + 2'd1;
                    end
                end
            end

            ST_HALT: begin
                t_state_d = T_NONE;
            end

            default: begin
                state_d   = ST_IDLE;
                upc_d     = FETCH_BASE;
                t_state_d = T_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            upc_q      <= FETCH_BASE;
            t_state_q  <= T_NONE;
            step_cnt_q <= 2'd0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            upc_q      <= upc_d;
            t_state_q  <= t_state_d;
            step_cnt_q <= step_cnt_d;
            illegal_q  <= illegal_d;
        end
    end

    assign bus.upc        = upc_q;
    assign bus.t_state    = t_state_q;
    assign bus.running    = (state_q == ST_FETCH) || (state_q == ST_EXEC);
    assign bus.halted     = (state_q == ST_HALT);
    assign bus.illegal_op = illegal_q;

endmodule

// File: tb/tb_sap_1_microprogram_sequencer.sv
// Table-driven, scoreboarded bench for the SAP-1 microprogram sequencer (default build).
`timescale 1ns/1ps
module tb_sap_1_microprogram_sequencer;

    typedef struct packed {
        logic [7:0] upc;
        logic [5:0] t;
        logic       run;
        logic       halt;
        logic       ill;
    } exp_t;

    typedef struct packed {
        logic        rst_n;
        logic        start;
        logic [15:0] op;
        logic [7:0]  map;
        logic        mi_end;
        logic        hlt;
        exp_t        exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   passed;
    exp_t sb[$];

    sap_1_microprogram_sequencer_if bus();

    sap_1_microprogram_sequencer #(
        .FETCH_BASE(8'h00),
        .EXEC_STEPS(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rn, input logic st, input logic [15:0] op,
                                input logic [7:0] ma, input logic me, input logic h,
                                input logic [7:0] eu, input logic [5:0] et,
                                input logic er, input logic eh, input logic ei);
        vec_t v;
        v.rst_n    = rn;
        v.start    = st;
        v.op       = op;
        v.map      = ma;
        v.mi_end   = me;
        v.hlt      = h;
        v.exp.upc  = eu;
        v.exp.t    = et;
        v.exp.run  = er;
        v.exp.halt = eh;
        v.exp.ill  = ei;
        return v;
    endfunction

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic apply(input vec_t v, input string name);
        exp_t got;
        exp_t want;
        @(negedge clk);
        rst_n         = v.rst_n;
        bus.start     = v.start;
        bus.op_onehot = v.op;
        bus.map_addr  = v.map;
        bus.mi_end    = v.mi_end;
        bus.hlt       = v.hlt;
        sb.push_back(v.exp);
        @(posedge clk);
        #1;
        got.upc  = bus.upc;
        got.t    = bus.t_state;
        got.run  = bus.running;
        got.halt = bus.halted;
        got.ill  = bus.illegal_op;
        want = sb.pop_front();
        checks++;
        if (got !== want) begin
            $display("FAIL %s: got upc=%h t=%b run=%b halt=%b ill=%b, need upc=%h t=%b run=%b halt=%b ill=%b",
                     name, got.upc, got.t, got.run, got.halt, got.ill,
                     want.upc, want.t, want.run, want.halt, want.ill);
        end else begin
            passed++;
            $display("ok   %s: upc=%h t=%b run=%b halt=%b ill=%b",
                     name, got.upc, got.t, got.run, got.halt, got.ill);
        end
    endtask

    vec_t vecs [36];

    initial begin
        checks        = 0;
        passed        = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.op_onehot = 16'h0000;
        bus.map_addr  = 8'h00;
        bus.mi_end    = 1'b0;
        bus.hlt       = 1'b0;
`ifdef SAP_1_SINGLE_STEP_EN
        bus.step_mode = 1'b0;
        bus.step      = 1'b0;
`endif

        //             rn  st  op        map    me  h   upc    t          run halt ill
        vecs[0]  = mk(0, 0, 16'h0000, 8'h00, 0, 0, 8'h00, 6'b000000, 0, 0, 0);
        vecs[1]  = mk(0, 0, 16'h0000, 8'h00, 0, 0, 8'h00, 6'b000000, 0, 0, 0);
        vecs[2]  = mk(1, 0, 16'h0000, 8'h00, 0, 0, 8'h00, 6'b000000, 0, 0, 0);
        vecs[3]  = mk(1, 1, 16'h0000, 8'h00, 0, 0, 8'h00, 6'b000001, 1, 0, 0);
        vecs[4]  = mk(1, 0, 16'h0000, 8'h00, 0, 0, 8'h01, 6'b000010, 1, 0, 0);
        vecs[5]  = mk(1, 0, 16'h0000, 8'h00, 0, 0, 8'h02, 6'b000100, 1, 0, 0);
        // LDA: full three-step routine
        vecs[6]  = mk(1, 0, 16'h0001, 8'h09, 0, 0, 8'h09, 6'b001000, 1, 0, 0);
        vecs[7]  = mk(1, 0, 16'h0001, 8'h09, 0, 0, 8'h0A, 6'b010000, 1, 0, 0);
        vecs[8]  = mk(1, 0, 16'h0001, 8'h09, 0, 0, 8'h0B, 6'b100000, 1, 0, 0);
        vecs[9]  = mk(1, 0, 16'h0001, 8'h09, 0, 0, 8'h00, 6'b000001, 1, 0, 0);
        // Early end after one execute step
        vecs[10] = mk(1, 0, 16'h0001, 8'h20, 0, 0, 8'h01, 6'b000010, 1, 0, 0);
        vecs[11] = mk(1, 0, 16'h0001, 8'h20, 0, 0, 8'h02, 6'b000100, 1, 0, 0);
        vecs[12] = mk(1, 0, 16'h0001, 8'h20, 0, 0, 8'h20, 6'b001000, 1, 0, 0);
        vecs[13] = mk(1, 0, 16'h0001, 8'h20, 1, 0, 8'h00, 6'b000001, 1, 0, 0);
        // Illegal two-hot opcode, then a legal instruction keeps the flag
        vecs[14] = mk(1, 0, 16'h0003, 8'h00, 0, 0, 8'h01, 6'b000010, 1, 0, 0);
        vecs[15] = mk(1, 0, 16'h0003, 8'h00, 0, 0, 8'h02, 6'b000100, 1, 0, 0);
        vecs[16] = mk(1, 0, 16'h0003, 8'h00, 0, 0, 8'h00, 6'b000001, 1, 0, 1);
        vecs[17] = mk(1, 0, 16'h0004, 8'h30, 0, 0, 8'h01, 6'b000010, 1, 0, 1);
        vecs[18] = mk(1, 0, 16'h0004, 8'h30, 0, 0, 8'h02, 6'b000100, 1, 0, 1);
        vecs[19] = mk(1, 0, 16'h0004, 8'h30, 0, 0, 8'h30, 6'b001000, 1, 0, 1);
        vecs[20] = mk(1, 0, 16'h0004, 8'h30, 1, 0, 8'h00, 6'b000001, 1, 0, 1);
        // mi_end held during fetch has no effect
        vecs[21] = mk(1, 0, 16'h8000, 8'hFE, 1, 0, 8'h01, 6'b000010, 1, 0, 1);
        vecs[22] = mk(1, 0, 16'h8000, 8'hFE, 1, 0, 8'h02, 6'b000100, 1, 0, 1);
        // upc wraps FF -> 00 inside a routine
        vecs[23] = mk(1, 0, 16'h8000, 8'hFE, 0, 0, 8'hFE, 6'b001000, 1, 0, 1);
        vecs[24] = mk(1, 0, 16'h8000, 8'hFE, 0, 0, 8'hFF, 6'b010000, 1, 0, 1);
        vecs[25] = mk(1, 0, 16'h8000, 8'hFE, 0, 0, 8'h00, 6'b100000, 1, 0, 1);
        vecs[26] = mk(1, 0, 16'h8000, 8'hFE, 0, 0, 8'h00, 6'b000001, 1, 0, 1);
        // Zero opcode is illegal too
        vecs[27] = mk(1, 0, 16'h0000, 8'h44, 0, 0, 8'h01, 6'b000010, 1, 0, 1);
        vecs[28] = mk(1, 0, 16'h0000, 8'h44, 0, 0, 8'h02, 6'b000100, 1, 0, 1);
        vecs[29] = mk(1, 0, 16'h0000, 8'h44, 0, 0, 8'h00, 6'b000001, 1, 0, 1);
        // HLT, start ignored while halted, reset clears everything
        vecs[30] = mk(1, 0, 16'h0000, 8'h00, 0, 0, 8'h01, 6'b000010, 1, 0, 1);
        vecs[31] = mk(1, 0, 16'h0000, 8'h00, 0, 0, 8'h02, 6'b000100, 1, 0, 1);
        vecs[32] = mk(1, 0, 16'h0100, 8'h00, 0, 1, 8'h02, 6'b000000, 0, 1, 1);
        vecs[33] = mk(1, 1, 16'h0100, 8'h00, 0, 0, 8'h02, 6'b000000, 0, 1, 1);
        vecs[34] = mk(1, 1, 16'h0100, 8'h00, 1, 0, 8'h02, 6'b000000, 0, 1, 1);
        vecs[35] = mk(0, 0, 16'h0000, 8'h00, 0, 0, 8'h00, 6'b000000, 0, 0, 0);

        for (int i = 0; i < 36; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // HLT together with an illegal opcode: halt wins, flag stays clear
        apply(mk(1, 1, 16'h0000, 8'h00, 0, 0, 8'h00, 6'b000001, 1, 0, 0), "hltill_t1");
        apply(mk(1, 0, 16'h0000, 8'h00, 0, 0, 8'h01, 6'b000010, 1, 0, 0), "hltill_t2");
        apply(mk(1, 0, 16'h0000, 8'h00, 0, 0, 8'h02, 6'b000100, 1, 0, 0), "hltill_t3");
        apply(mk(1, 0, 16'h0003, 8'h00, 0, 1, 8'h02, 6'b000000, 0, 1, 0), "hltill_halt");
        apply(mk(0, 0, 16'h0000, 8'h00, 0, 0, 8'h00, 6'b000000, 0, 0, 0), "hltill_rst");

        // Reset in the middle of an execute routine (at T5)
        apply(mk(1, 1, 16'h0000, 8'h00, 0, 0, 8'h00, 6'b000001, 1, 0, 0), "midrst_t1");
        apply(mk(1, 0, 16'h0000, 8'h00, 0, 0, 8'h01, 6'b000010, 1, 0, 0), "midrst_t2");
        apply(mk(1, 0, 16'h0000, 8'h00, 0, 0, 8'h02, 6'b000100, 1, 0, 0), "midrst_t3");
        apply(mk(1, 0, 16'h0001, 8'h40, 0, 0, 8'h40, 6'b001000, 1, 0, 0), "midrst_t4");
        apply(mk(1, 0, 16'h0001, 8'h40, 0, 0, 8'h41, 6'b010000, 1, 0, 0), "midrst_t5");
        apply(mk(0, 1, 16'h0001, 8'h40, 0, 0, 8'h00, 6'b000000, 0, 0, 0), "midrst_rst");
        apply(mk(0, 1, 16'h0001, 8'h40, 0, 0, 8'h00, 6'b000000, 0, 0, 0), "midrst_hold");

        // mi_end on the last allowed step returns to fetch exactly once
        apply(mk(1, 1, 16'h0000, 8'h00, 0, 0, 8'h00, 6'b000001, 1, 0, 0), "last_t1");
        apply(mk(1, 0, 16'h0000, 8'h00, 0, 0, 8'h01, 6'b000010, 1, 0, 0), "last_t2");
        apply(mk(1, 0, 16'h0000, 8'h00, 0, 0, 8'h02, 6'b000100, 1, 0, 0), "last_t3");
        apply(mk(1, 0, 16'h0002, 8'h50, 0, 0, 8'h50, 6'b001000, 1, 0, 0), "last_t4");
        apply(mk(1, 0, 16'h0002, 8'h50, 0, 0, 8'h51, 6'b010000, 1, 0, 0), "last_t5");
        apply(mk(1, 0, 16'h0002, 8'h50, 0, 0, 8'h52, 6'b100000, 1, 0, 0), "last_t6");
        apply(mk(1, 0, 16'h0002, 8'h50, 1, 0, 8'h00, 6'b000001, 1, 0, 0), "last_ret");
        apply(mk(1, 0, 16'h0002, 8'h50, 0, 0, 8'h01, 6'b000010, 1, 0, 0), "last_next");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
